// File: rtl/draw_seq_pkg.sv
// rtl/draw_seq_pkg.sv - shared state type, coordinate widths and helpers for the draw sequencer
// Contents: state_e FSM encoding, X_W/Y_W/COL_W widths, default erase colour,
//           pass_w() returning the pass-index width for a given object count.
package draw_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        LOAD,
        DRAW,
        NEXT
    } state_e;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    localparam logic [COL_W-1:0] ERASE_COLOUR_DEF = 3'b000;

    // Width of an index that spans all 2*num_obj passes of one frame.
    function automatic int pass_w(input int num_obj);
        return (num_obj > 1) ? $clog2(2 * num_obj) : 1;
    endfunction

endpackage

// File: rtl/obj_snapshot.sv
// rtl/obj_snapshot.sv - current/previous object banks and per-pass rectangle select
// Optional feature macro: SKIP_STATIC_EN (per-object moved vector gates the pass list).
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   snap_i                capture obj_*_i into the current bank
//   commit_i              copy current positions to the previous bank, set prev_valid
//   obj_*_i               packed per-object x, y, w, h, colour
//   pass_i                pass index selecting the rectangle on sel_*_o
//   sel_*_o               rectangle for the selected pass
//   req_now_o             required-pass vector computed from live inputs (used in SNAP)
//   req_o                 required-pass vector for the captured frame (used in NEXT)
module obj_snapshot
    import draw_seq_pkg::*;
#(
    parameter int               NUM_OBJ      = 3,
    parameter logic [COL_W-1:0] ERASE_COLOUR = ERASE_COLOUR_DEF,
    parameter int               PASS_W       = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     snap_i,
    input  logic                     commit_i,
    input  logic [X_W*NUM_OBJ-1:0]   obj_x_i,
    input  logic [Y_W*NUM_OBJ-1:0]   obj_y_i,
    input  logic [X_W*NUM_OBJ-1:0]   obj_w_i,
    input  logic [Y_W*NUM_OBJ-1:0]   obj_h_i,
    input  logic [COL_W*NUM_OBJ-1:0] obj_colour_i,
    input  logic [PASS_W-1:0]        pass_i,
    output logic [X_W-1:0]           sel_x_o,
    output logic [Y_W-1:0]           sel_y_o,
    output logic [X_W-1:0]           sel_w_o,
    output logic [Y_W-1:0]           sel_h_o,
    output logic [COL_W-1:0]         sel_colour_o,
    output logic [2*NUM_OBJ-1:0]     req_now_o,
    output logic [2*NUM_OBJ-1:0]     req_o
);

    logic [X_W*NUM_OBJ-1:0]   cur_x_q, prev_x_q, cur_w_q;
    logic [Y_W*NUM_OBJ-1:0]   cur_y_q, prev_y_q, cur_h_q;
    logic [COL_W*NUM_OBJ-1:0] cur_c_q;
    logic                     prev_valid_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_w_q      <= '0;
            cur_h_q      <= '0;
            cur_c_q      <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            if (snap_i) begin
                cur_x_q <= obj_x_i;
                cur_y_q <= obj_y_i;
                cur_w_q <= obj_w_i;
                cur_h_q <= obj_h_i;
                cur_c_q <= obj_colour_i;
            end
            if (commit_i) begin
                prev_x_q     <= cur_x_q;
                prev_y_q     <= cur_y_q;
                prev_valid_q <= 1'b1;
            end
        end
    end

    // Passes 0..NUM_OBJ-1 erase at the old position using the new size, the
    // remaining passes draw at the new position.
    int   obj_idx;
    logic erase;

    always_comb begin
        erase   = (int'(pass_i) < NUM_OBJ);
        obj_idx = erase ? int'(pass_i) : int'(pass_i) - NUM_OBJ;
        if (obj_idx >= NUM_OBJ) begin
            obj_idx = 0;
        end
        sel_w_o = cur_w_q[obj_idx*X_W +: X_W];
        sel_h_o = cur_h_q[obj_idx*Y_W +: Y_W];
        if (erase) begin
            sel_x_o      = prev_x_q[obj_idx*X_W +: X_W];
            sel_y_o      = prev_y_q[obj_idx*Y_W +: Y_W];
            sel_colour_o = ERASE_COLOUR;
        end else begin
            sel_x_o      = cur_x_q[obj_idx*X_W +: X_W];
            sel_y_o      = cur_y_q[obj_idx*Y_W +: Y_W];
            sel_colour_o = cur_c_q[obj_idx*COL_W +: COL_W];
        end
    end

`ifdef SKIP_STATIC_EN
    logic [NUM_OBJ-1:0] moved_d, moved_q;

    always_comb begin
        moved_d = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            moved_d[i] = !prev_valid_q
                       || (obj_x_i[i*X_W +: X_W] != prev_x_q[i*X_W +: X_W])
                       || (obj_y_i[i*Y_W +: Y_W] != prev_y_q[i*Y_W +: Y_W]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            moved_q <= '0;
        end else if (snap_i) begin
            moved_q <= moved_d;
        end
    end

    assign req_now_o = {moved_d, moved_d & {NUM_OBJ{prev_valid_q}}};
    assign req_o     = {moved_q, moved_q & {NUM_OBJ{prev_valid_q}}};
`else
    // Every draw pass runs; erase passes run once a previous frame exists.
    assign req_now_o = {{NUM_OBJ{1'b1}}, {NUM_OBJ{prev_valid_q}}};
    assign req_o     = req_now_o;
`endif

endmodule

// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - per-frame erase/draw pass sequencer feeding the rectangle drawer
// Optional feature macro: SKIP_STATIC_EN (skip passes of objects that did not move).
// Ports:
//   clock, reset_n        clock and synchronous active-low reset
//   frame_tick            frame-rate pulse starting a frame (accepted only in IDLE)
//   obj_x/y/w/h/colour    packed per-object geometry and colour
//   draw_done             drawer finished the current rectangle
//   drw_load/enable       drawer latch strobe and count enable
//   drw_x/y/w/h/colour    rectangle for the current pass
//   plot                  VGA write enable
//   busy                  frame in progress
//   frame_overrun         sticky: a tick arrived while busy
module draw_sequencer
    import draw_seq_pkg::*;
#(
    parameter int               NUM_OBJ      = 3,
    parameter logic [COL_W-1:0] ERASE_COLOUR = ERASE_COLOUR_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    input  logic [X_W*NUM_OBJ-1:0]   obj_x,
    input  logic [Y_W*NUM_OBJ-1:0]   obj_y,
    input  logic [X_W*NUM_OBJ-1:0]   obj_w,
    input  logic [Y_W*NUM_OBJ-1:0]   obj_h,
    input  logic [COL_W*NUM_OBJ-1:0] obj_colour,
    input  logic                     draw_done,
    output logic                     drw_load,
    output logic                     drw_enable,
    output logic [X_W-1:0]           drw_x,
    output logic [Y_W-1:0]           drw_y,
    output logic [X_W-1:0]           drw_w,
    output logic [Y_W-1:0]           drw_h,
    output logic [COL_W-1:0]         drw_colour,
    output logic                     plot,
    output logic                     busy,
    output logic                     frame_overrun
);

    localparam int            NPASS     = 2 * NUM_OBJ;
    localparam int            PW        = pass_w(NUM_OBJ);
    localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

    state_e        state_q;
    logic [PW-1:0] pass_q;
    logic          load_q, enable_q, plot_q, busy_q, overrun_q;
    logic [NPASS-1:0] req_now, req;
    logic [PW:0]   first_hit, next_hit;
    logic          snap, commit;

    // Lowest required pass at or above 'from'; MSB flags that one exists.
    function automatic logic [PW:0] find_req(input logic [NPASS-1:0] vec, input int from);
        logic [PW:0] hit;
        hit = '0;
        for (int k = NPASS - 1; k >= 0; k--) begin
            if (k >= from && vec[k]) begin
                hit = {1'b1, PW'(k)};
            end
        end
        return hit;
    endfunction

    assign first_hit = find_req(req_now, 0);
    assign next_hit  = find_req(req, int'(pass_q) + 1);
    assign snap      = (state_q == SNAP);
    assign commit    = (state_q == NEXT) && !next_hit[PW];

    obj_snapshot #(
        .NUM_OBJ      (NUM_OBJ),
        .ERASE_COLOUR (ERASE_COLOUR),
        .PASS_W       (PW)
    ) u_snapshot (
        .clock        (clock),
        .reset_n      (reset_n),
        .snap_i       (snap),
        .commit_i     (commit),
        .obj_x_i      (obj_x),
        .obj_y_i      (obj_y),
        .obj_w_i      (obj_w),
        .obj_h_i      (obj_h),
        .obj_colour_i (obj_colour),
        .pass_i       (pass_q),
        .sel_x_o      (drw_x),
        .sel_y_o      (drw_y),
        .sel_w_o      (drw_w),
        .sel_h_o      (drw_h),
        .sel_colour_o (drw_colour),
        .req_now_o    (req_now),
        .req_o        (req)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pass_q    <= '0;
            load_q    <= 1'b0;
            enable_q  <= 1'b0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (frame_tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= SNAP;
                        busy_q  <= 1'b1;
                    end
                end
                SNAP: begin
                    if (first_hit[PW]) begin
                        pass_q  <= first_hit[PW-1:0];
                        load_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        // Nothing to draw: park on the last pass so NEXT finishes.
                        pass_q  <= LAST_PASS;
                        state_q <= NEXT;
                    end
                end
                LOAD: begin
                    load_q   <= 1'b0;
                    enable_q <= 1'b1;
                    plot_q   <= 1'b1;
                    state_q  <= DRAW;
                end
                DRAW: begin
                    if (draw_done) begin
                        enable_q <= 1'b0;
                        plot_q   <= 1'b0;
                        state_q  <= NEXT;
                    end
                end
                NEXT: begin
                    if (next_hit[PW]) begin
                        pass_q  <= next_hit[PW-1:0];
                        load_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign drw_load      = load_q;
    assign drw_enable    = enable_q;
    assign plot          = plot_q;
    assign busy          = busy_q;
    assign frame_overrun = overrun_q;

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Frame-level controller directly upstream of the rectangle drawer.
- On each frame tick it snapshots the positions of all game objects (two paddles and the puck).
- It drives the drawer through one erase pass per object at the object's previous position, then one draw pass per object at its new position.
- Its outputs feed the drawer's load, enable, position, size and colour inputs, and gate the VGA plot strobe.

Parameters:
- NUM_OBJ, 3, number of objects sequenced per frame (passes per frame = 2*NUM_OBJ).
- ERASE_COLOUR, 3'b000, colour driven during erase passes.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at frame rate.
- obj_x  in  8*NUM_OBJ  packed x positions; object i at [8i+7:8i].
- obj_y  in  7*NUM_OBJ  packed y positions.
- obj_w  in  8*NUM_OBJ  packed widths minus one, in drawer convention.
- obj_h  in  7*NUM_OBJ  packed heights minus one.
- obj_colour  in  3*NUM_OBJ  packed draw colours.
- draw_done  in  1  drawer completion pulse (last pixel plotted).
- drw_load  out  1  drawer latch/clear strobe, active high.
- drw_enable  out  1  drawer count enable.
- drw_x  out  8  rectangle origin x.
- drw_y  out  7  rectangle origin y.
- drw_w  out  8  rectangle width.
- drw_h  out  7  rectangle height.
- drw_colour  out  3  pass colour.
- plot  out  1  VGA write enable.
- busy  out  1  high from frame accept to end of last pass.
- frame_overrun  out  1  sticky; tick arrived while busy.

Behaviour:
- Reset (reset_n==0 at a clock edge) overrides everything:
  - All outputs go to 0; state IDLE; pass index 0; prev_valid 0.
  - Snapshot and previous-position registers are cleared.
  - Reset mid-frame abandons the frame; no further plot.
- States:
  - IDLE -> SNAP on frame_tick.
  - SNAP (1 cycle): cur[i] <= obj inputs for all i. Pass index <= 0 if prev_valid, else NUM_OBJ (erase passes skipped on the first frame). -> LOAD.
  - LOAD (1 cycle): drw_load=1, drw_enable=0. Drive drw_* from the pass select. -> DRAW.
  - DRAW: drw_enable=1, plot=1. drw_* are held stable. On draw_done -> NEXT. The DRAW cycle in which draw_done is sampled still plots.
  - NEXT (1 cycle): enable and plot low.
    - If pass index == 2*NUM_OBJ-1: prev[i] <= cur[i] for all i, prev_valid <= 1, -> IDLE.
    - Else: pass index +1, -> LOAD.
- Pass select:
  - Pass p < NUM_OBJ erases object p: prev x/y, cur w/h, ERASE_COLOUR.
  - Pass p >= NUM_OBJ draws object p-NUM_OBJ: cur x/y/w/h/colour.
- Positions are never modified arithmetically. Drawer-side addition wraps; screen clipping is the drawer's responsibility.
- busy = (state != IDLE). It is 1 from the SNAP cycle through NEXT of the final pass.
- frame_tick while busy:
  - The tick is ignored and the current frame continues.
  - frame_overrun <= 1 and stays set until reset.
- frame_tick in the same cycle as the final NEXT:
  - Also counts as an overrun and is dropped.
  - Acceptance happens only in IDLE.
- draw_done outside DRAW is ignored.
- Input changes after SNAP have no effect until the next frame.
- Latency: frame_tick at cycle t -> SNAP at t+1 -> drw_load at t+2 -> first plot at t+3.

Optional Feature:
- SKIP_STATIC_EN, defined:
  - In SNAP, compute per-object moved[i] = !prev_valid | (cur x,y != prev x,y).
  - Erase and draw passes of objects with moved[i]==0 are skipped. NEXT advances to the next required pass, or finishes if none remain.
  - A frame with nothing moved goes SNAP -> NEXT -> IDLE; prev is still updated.
- Not defined: every frame performs all required passes. moved logic is absent.

Decomposition:
- Package draw_seq_pkg:
  - State enum {IDLE, SNAP, LOAD, DRAW, NEXT}.
  - Coordinate widths X_W=8, Y_W=7, COL_W=3.
  - ERASE_COLOUR default.
  - Pass-index width function clog2(2*NUM_OBJ).
- One sub-module, obj_snapshot: holds the cur/prev register banks, the prev_valid flag and the pass-select mux (including the moved vector when the feature is enabled). The FSM stays in draw_sequencer.

Test Plan:
- First frame after reset, NUM_OBJ=3, objects at (10,20),(140,20),(80,60), draw_done returned 5 cycles after each load:
  - Exactly 3 passes in draw order, no erase pass.
  - drw_colour equals obj_colour.
  - busy falls after the third NEXT.
- Second frame with object 0 moved to (12,22):
  - Passes 0-2 erase at (10,20),(140,20),(80,60) with colour 000.
  - Passes 3-5 draw at (12,22),(140,20),(80,60).
  - With SKIP_STATIC_EN: one erase at (10,20), then one draw at (12,22).
- frame_tick pulsed during pass 2 DRAW:
  - frame_overrun=1 and the frame completes unchanged.
  - No second SNAP until the next tick arriving in IDLE.
- obj_x changed during DRAW: drw_x is unchanged until the next frame's SNAP.
- reset_n=0 for one cycle mid pass 4:
  - Next cycle plot=0, busy=0, frame_overrun=0.
  - The following frame has no erase passes.
- draw_done pulsed while IDLE or LOAD: no state change, no plot.
